// File: rtl/cdc_2phase_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of a cdc_2phase source port.
package cdc_2phase_arb_pkg;

  typedef enum logic {ARB_EMPTY = 1'b0, ARB_FULL = 1'b1} arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import cdc_2phase_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  int   w_best_d;
  int   w_best_i;
  int   w_d;
  logic w_found;

  // Distance from ptr decides priority; smallest distance among valid requesters wins.
  always_comb begin
    w_best_d = NUM_REQ;
    w_best_i = 0;
    w_d      = 0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_d = i - int'(ptr);
      if (w_d < 0) w_d = w_d + NUM_REQ;
      if (req[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_best_i = i;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) grant[i] = w_found && (i == w_best_i);
    grant_idx = ID_WIDTH'(w_best_i);
  end

endmodule

// File: rtl/cdc_2phase_rr_arb.sv
// Round-robin arbiter feeding one cdc_2phase source channel through a one-entry tagged register.
// Optional stall watchdog enabled with `define CDC_2PHASE_ARB_TIMEOUT_EN.
module cdc_2phase_rr_arb
  import cdc_2phase_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int ID_WIDTH    = id_width(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           out_valid_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] out_data_o,
  input  logic                           out_ready_i,
  input  logic                           timeout_clr_i,
  output logic                           timeout_o
);

  arb_state_e                     r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]            r_ptr;
  logic [ID_WIDTH-1:0]            w_grant_idx;
  logic [NUM_REQ-1:0]             w_grant;
  logic [DATA_WIDTH-1:0]          w_gnt_data;
  logic [ID_WIDTH+DATA_WIDTH-1:0] r_data;
  logic                           w_can_accept;
  logic                           w_hs;
  logic                           w_drain;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid_i),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Ready is gated during reset since the EMPTY state alone would otherwise advertise acceptance.
  assign w_can_accept = (r_state == ARB_EMPTY) || out_ready_i;
  assign req_ready_o  = (w_can_accept && !rst_i) ? w_grant : '0;
  assign w_hs         = |req_ready_o;
  assign w_drain      = out_valid_o && out_ready_i;

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_gnt_data = w_gnt_data | (req_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ARB_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_hs)         w_state_nxt = ARB_FULL;
    else if (w_drain) w_state_nxt = ARB_EMPTY;
  end

  always_comb begin
    out_valid_o = (r_state == ARB_FULL);
    out_data_o  = r_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_ptr  <= '0;
    end else if (w_hs) begin
      r_data <= {w_grant_idx, w_gnt_data};
      if (int'(w_grant_idx) == NUM_REQ - 1) r_ptr <= '0;
      else                                  r_ptr <= w_grant_idx + 1'b1;
    end
  end

`ifdef CDC_2PHASE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout;

  // Counter saturates at TIMEOUT_CYC; the flag is raised one edge after it gets there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else if (timeout_clr_i) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (r_stall_cnt == CNT_W'(TIMEOUT_CYC)) r_timeout <= 1'b1;
      if (out_valid_o && !out_ready_i) begin
        if (r_stall_cnt != CNT_W'(TIMEOUT_CYC)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused;
  assign w_unused  = timeout_clr_i | (TIMEOUT_CYC < 2);
  assign timeout_o = 1'b0;
`endif

endmodule
